beep_scheduler: RTL and testbench
=================================

# beep_scheduler

Sequences and arbitrates the calculator's single buzzer between live keypad tones and short event melodies for result OK, error and clear. It sits between the keypad scanner / calculator FSM and `buzzer_driver`, and drives that driver's 16-bit `key_status` input with a one-hot tone select. Note and gap durations are set in milliseconds from a prescaled tick, so melodies are clock-rate independent.

## Interface
- `TICKS_PER_MS`, default 100000: clk cycles per millisecond; benches override to a small value.
- `NOTE_MS`, default 120: duration of each melody note in ms; must be ≥ 1.
- `GAP_MS`, default 30: silence between melody notes in ms; 0 means no gap.
- `clk  in  1`: system clock; every register is clocked on its rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `key_status  in  16`: live debounced keypad state, may be multi-hot.
- `evt_ok  in  1`: single-cycle pulse, result OK.
- `evt_err  in  1`: single-cycle pulse, error.
- `evt_clr  in  1`: single-cycle pulse, clear.
- `tone_sel  out  16`: one-hot (or zero) tone select; connects to `buzzer_driver.key_status`.
- `busy  out  1`: high while a melody plays.
- `mel_id  out  2`: melody in progress. 0 = none, 1 = CLR, 2 = OK, 3 = ERR.

## Operation
- **Tone encoding:** tone index i drives `tone_sel = 1 << i`.
- **Melody ROM** (tone indices, in order):
  - OK = 7, 3, 0 (rising).
  - ERR = 12, 15 (falling).
  - CLR = 8 (one note).
- **Priority:** ERR (3) > OK (2) > CLR (1).
- **FSM states:** IDLE, NOTE, GAP.
- **IDLE:**
  - `tone_sel` is the registered priority encode of `key_status`: lowest set bit only, all other bits 0.
  - `key_status == 0` gives `tone_sel = 0`.
  - `busy` = 0 and `mel_id` = 0.
- **Event start from IDLE:**
  - If any event pulse is high, the highest-priority one is accepted. Simultaneous lower-priority pulses are dropped.
  - Go to NOTE with note pointer = 0. `mel_id` takes the accepted ID and `busy` = 1.
  - The prescaler and ms counter clear.
- **NOTE:**
  - `tone_sel` = one-hot of the current ROM entry; live keys are muted.
  - The note lasts exactly N = NOTE_MS·TICKS_PER_MS cycles.
  - At the end of the last note, go to IDLE.
  - Otherwise go to GAP, or directly to the next NOTE if GAP_MS = 0.
- **GAP:**
  - `tone_sel` = 0 for exactly G = GAP_MS·TICKS_PER_MS cycles.
  - Then go to NOTE with the pointer incremented.
- **Preemption during a melody (NOTE or GAP):**
  - An event with strictly higher priority than `mel_id` restarts the machine at NOTE, pointer 0, with the new melody. Counters clear.
  - An event with equal or lower priority is dropped; no queueing.
- **Counters:**
  - The prescaler counts 0..TICKS_PER_MS-1 and wraps; each wrap advances the ms counter.
  - Both clear on every state entry, so durations are exact and not phase-dependent.
  - Widths: prescaler uses $clog2(TICKS_PER_MS); ms counter uses $clog2(max(NOTE_MS,GAP_MS)+1).
- **Returning to IDLE:** a live key still held sounds again from the first IDLE cycle. No memory of keys pressed during the melody.

## Timing
- **Reset:** on an edge with `rst` = 1:
  - State = IDLE, `tone_sel` = 0, `busy` = 0, `mel_id` = 0.
  - Counters and pointer = 0; any melody is aborted.
  - `rst` overrides events in the same cycle.
- **Live key latency:** 1 cycle. A `key_status` change at edge k appears on `tone_sel` after edge k.
- **Event latency:** an event sampled at edge t puts the first note on `tone_sel`, plus `busy` and `mel_id`, from edge t+1.
- **Melody lengths:**
  - OK = 3N+2G cycles; ERR = 2N+G; CLR = N.
  - `busy` is high for exactly that many cycles and falls on the same edge that `tone_sel` returns to live.
- **Back-to-back events:**
  - An event arriving on the cycle the last note ends is evaluated as from IDLE, so it is accepted.
  - No dead cycle: `busy` stays high.
- **Preemption:** takes effect on the edge after the preempting pulse. The new first note is visible from that edge.
- **Output form:** `tone_sel` is never multi-hot, and it changes only on clock edges (registered output).

## Test plan
Bench parameters: TICKS_PER_MS = 2, NOTE_MS = 3, GAP_MS = 1, giving N = 6 and G = 2.
- **Reset:** assert `rst` 3 cycles with `key_status` = 0x0010 and `evt_ok` pulsing -> `tone_sel` = 0, `busy` = 0 and `mel_id` = 0 throughout. After release, `tone_sel` = 0x0010 on the next edge.
- **Live priority encode:** `key_status` = 0x0A00 -> `tone_sel` = 0x0200. `key_status` = 0 -> `tone_sel` = 0 next cycle.
- **OK melody:** `evt_ok` pulse with no keys held -> `tone_sel` sequence is:
  - 0x0080 ×6, 0 ×2, 0x0008 ×6, 0 ×2, 0x0001 ×6.
  - `busy` high for exactly 22 cycles, `mel_id` = 2, then 0.
- **Preemption:** `evt_ok` at t, `evt_err` at t+4 -> 0x0080 for 4 cycles, then 0x1000 ×6, 0 ×2, 0x8000 ×6, with `mel_id` = 3. An `evt_clr` during ERR is ignored.
- **Simultaneous events:** `evt_clr` and `evt_ok` in the same cycle -> OK melody only. `evt_clr` during OK -> dropped, total OK length unchanged.
- **Mute and resume:** hold `key_status` = 0x0004 and pulse `evt_clr` -> `tone_sel` = 0x0100 for 6 cycles, then 0x0004 with no gap cycle. A fresh `evt_clr` on the final note cycle restarts CLR with `busy` never dropping.

Source files
------------

// File: rtl/beep_scheduler.sv
// Buzzer arbiter: live keypad tones in IDLE, prioritised event melodies (ERR > OK > CLR)
// timed in milliseconds from a prescaled tick. tone_sel is a registered one-hot select.
module beep_scheduler #(
  parameter int TICKS_PER_MS = 100000,
  parameter int NOTE_MS      = 120,
  parameter int GAP_MS       = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] key_status,
  input  logic        evt_ok,
  input  logic        evt_err,
  input  logic        evt_clr,
  output logic [15:0] tone_sel,
  output logic        busy,
  output logic [1:0]  mel_id
);
  localparam int MAXMS = (NOTE_MS > GAP_MS) ? NOTE_MS : GAP_MS;
  localparam int PW    = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int MW    = $clog2(MAXMS + 1);

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_e;

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    mel_q, mel_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [MW-1:0] ms_q, ms_d;
  logic [15:0]   tone_q, tone_d;

  logic [1:0] evt_id;
  logic       wrap, note_end, gap_end, start, clr_cnt;

  function automatic logic [3:0] rom_tone(input logic [1:0] mel, input logic [1:0] ptr);
    logic [3:0] t;
    t = 4'd0;
    case (mel)
      2'd1: t = 4'd8;
      2'd2: t = (ptr == 2'd0) ? 4'd7 : (ptr == 2'd1) ? 4'd3 : 4'd0;
      2'd3: t = (ptr == 2'd0) ? 4'd12 : 4'd15;
      default: t = 4'd0;
    endcase
    return t;
  endfunction

  function automatic logic [1:0] last_ptr(input logic [1:0] mel);
    return (mel == 2'd2) ? 2'd2 : (mel == 2'd3) ? 2'd1 : 2'd0;
  endfunction

  always_comb begin
    evt_id   = evt_err ? 2'd3 : evt_ok ? 2'd2 : evt_clr ? 2'd1 : 2'd0;
    wrap     = (pre_q == PW'(TICKS_PER_MS - 1));
    note_end = wrap && (ms_q == MW'(NOTE_MS - 1));
    gap_end  = wrap && (ms_q == MW'(GAP_MS - 1));
    state_d  = state_q;
    ptr_d    = ptr_q;
    mel_d    = mel_q;
    start    = 1'b0;
    clr_cnt  = 1'b0;
    case (state_q)
      IDLE: start = (evt_id != 2'd0);
      NOTE: begin
        // End of the final note behaves like IDLE, so any event is accepted with no dead cycle
        if (note_end && ptr_q == last_ptr(mel_q)) begin
          if (evt_id != 2'd0) start = 1'b1;
          else begin
            state_d = IDLE;
            mel_d   = 2'd0;
            ptr_d   = 2'd0;
            clr_cnt = 1'b1;
          end
        end else if (evt_id > mel_q) begin
          start = 1'b1;
        end else if (note_end) begin
          clr_cnt = 1'b1;
          if (GAP_MS == 0) ptr_d = ptr_q + 2'd1;
          else             state_d = GAP;
        end
      end
      GAP: begin
        if (evt_id > mel_q) start = 1'b1;
        else if (gap_end) begin
          state_d = NOTE;
          ptr_d   = ptr_q + 2'd1;
          clr_cnt = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        mel_d   = 2'd0;
        ptr_d   = 2'd0;
      end
    endcase
    if (start) begin
      state_d = NOTE;
      ptr_d   = 2'd0;
      mel_d   = evt_id;
      clr_cnt = 1'b1;
    end

    pre_d = pre_q;
    ms_d  = ms_q;
    if (clr_cnt || state_d == IDLE) begin
      pre_d = '0;
      ms_d  = '0;
    end else if (wrap) begin
      pre_d = '0;
      ms_d  = ms_q + MW'(1);
    end else begin
      pre_d = pre_q + PW'(1);
    end

    case (state_d)
      NOTE:    tone_d = 16'(1) << rom_tone(mel_d, ptr_d);
      GAP:     tone_d = 16'd0;
      default: tone_d = key_status & (~key_status + 16'd1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      mel_q   <= '0;
      pre_q   <= '0;
      ms_q    <= '0;
      tone_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mel_q   <= mel_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
      tone_q  <= tone_d;
    end
  end

  assign tone_sel = tone_q;
  assign busy     = (state_q != IDLE);
  assign mel_id   = mel_q;
endmodule

// File: tb/tb_beep_scheduler.sv
// Directed vector table for beep_scheduler with N = 6, G = 2; each record's inputs are
// sampled at one edge and its expected outputs are checked just after that edge.
module tb_beep_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] key_status = 16'd0;
  logic        evt_ok = 1'b0, evt_err = 1'b0, evt_clr = 1'b0;
  logic [15:0] tone_sel;
  logic        busy;
  logic [1:0]  mel_id;

  beep_scheduler #(.TICKS_PER_MS(2), .NOTE_MS(3), .GAP_MS(1)) dut (
    .clk(clk), .rst(rst), .key_status(key_status),
    .evt_ok(evt_ok), .evt_err(evt_err), .evt_clr(evt_clr),
    .tone_sel(tone_sel), .busy(busy), .mel_id(mel_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] key;
    logic        ok, err, clr;
    logic [15:0] tone;
    logic        busy;
    logic [1:0]  mel;
  } vec_t;

  vec_t vq[$];
  int   applied = 0;
  int   errors  = 0;

  task automatic v(input logic r, input logic [15:0] k, input logic o, input logic e,
                   input logic c, input logic [15:0] t, input logic b, input logic [1:0] m);
    vec_t x;
    x.rst = r; x.key = k; x.ok = o; x.err = e; x.clr = c;
    x.tone = t; x.busy = b; x.mel = m;
    vq.push_back(x);
  endtask

  task automatic run(input int n, input logic [15:0] k, input logic [15:0] t,
                     input logic b, input logic [1:0] m);
    for (int i = 0; i < n; i++) v(1'b0, k, 1'b0, 1'b0, 1'b0, t, b, m);
  endtask

  initial begin
    int cnt;
    // reset with a held key and ok pulses
    v(1, 16'h0010, 1, 0, 0, 16'h0000, 0, 0);
    v(1, 16'h0010, 0, 0, 0, 16'h0000, 0, 0);
    v(1, 16'h0010, 1, 0, 0, 16'h0000, 0, 0);
    v(0, 16'h0010, 0, 0, 0, 16'h0010, 0, 0);
    // live priority encode
    v(0, 16'h0A00, 0, 0, 0, 16'h0200, 0, 0);
    v(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    v(0, 16'h8001, 0, 0, 0, 16'h0001, 0, 0);
    v(0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
    // OK melody, 22 busy cycles
    v(0, 16'h0000, 1, 0, 0, 16'h0080, 1, 2);
    run(5, 16'h0, 16'h0080, 1, 2);
    run(2, 16'h0, 16'h0000, 1, 2);
    run(6, 16'h0, 16'h0008, 1, 2);
    run(2, 16'h0, 16'h0000, 1, 2);
    run(6, 16'h0, 16'h0001, 1, 2);
    run(1, 16'h0, 16'h0000, 0, 0);
    // ERR preempts OK in its first note; CLR during ERR ignored
    v(0, 16'h0000, 1, 0, 0, 16'h0080, 1, 2);
    run(3, 16'h0, 16'h0080, 1, 2);
    v(0, 16'h0000, 0, 1, 0, 16'h1000, 1, 3);
    run(5, 16'h0, 16'h1000, 1, 3);
    v(0, 16'h0000, 0, 0, 1, 16'h0000, 1, 3);
    run(1, 16'h0, 16'h0000, 1, 3);
    run(6, 16'h0, 16'h8000, 1, 3);
    run(1, 16'h0, 16'h0000, 0, 0);
    // ERR preempts OK during a gap
    v(0, 16'h0000, 1, 0, 0, 16'h0080, 1, 2);
    run(5, 16'h0, 16'h0080, 1, 2);
    run(1, 16'h0, 16'h0000, 1, 2);
    v(0, 16'h0000, 0, 1, 0, 16'h1000, 1, 3);
    run(5, 16'h0, 16'h1000, 1, 3);
    run(2, 16'h0, 16'h0000, 1, 3);
    run(6, 16'h0, 16'h8000, 1, 3);
    run(1, 16'h0, 16'h0000, 0, 0);
    // simultaneous CLR+OK gives OK; CLR mid-OK dropped, length unchanged
    v(0, 16'h0000, 1, 0, 1, 16'h0080, 1, 2);
    run(5, 16'h0, 16'h0080, 1, 2);
    v(0, 16'h0000, 0, 0, 1, 16'h0000, 1, 2);
    run(1, 16'h0, 16'h0000, 1, 2);
    run(6, 16'h0, 16'h0008, 1, 2);
    run(2, 16'h0, 16'h0000, 1, 2);
    run(6, 16'h0, 16'h0001, 1, 2);
    run(1, 16'h0, 16'h0000, 0, 0);
    // mute and resume, then back-to-back CLR on the final note cycle
    run(1, 16'h0004, 16'h0004, 0, 0);
    v(0, 16'h0004, 0, 0, 1, 16'h0100, 1, 1);
    run(5, 16'h0004, 16'h0100, 1, 1);
    run(1, 16'h0004, 16'h0004, 0, 0);
    v(0, 16'h0004, 0, 0, 1, 16'h0100, 1, 1);
    run(5, 16'h0004, 16'h0100, 1, 1);
    v(0, 16'h0004, 0, 0, 1, 16'h0100, 1, 1);
    run(5, 16'h0004, 16'h0100, 1, 1);
    run(1, 16'h0004, 16'h0004, 0, 0);
    run(1, 16'h0000, 16'h0000, 0, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; key_status = vq[i].key;
      evt_ok = vq[i].ok; evt_err = vq[i].err; evt_clr = vq[i].clr;
      @(posedge clk); #1;
      applied++;
      if (tone_sel !== vq[i].tone || busy !== vq[i].busy || mel_id !== vq[i].mel) begin
        errors++;
        $display("FAIL vec[%0d]: got tone=%h busy=%b mel=%0d, expected tone=%h busy=%b mel=%0d",
                 i, tone_sel, busy, mel_id, vq[i].tone, vq[i].busy, vq[i].mel);
      end
    end

    // ERR length with a held key: 2N+G = 14 busy cycles, one-hot throughout, key resumes
    @(negedge clk);
    evt_ok = 0; evt_clr = 0; evt_err = 1; key_status = 16'h0002;
    @(posedge clk); #1;
    @(negedge clk);
    evt_err = 0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if ($countones(tone_sel) > 1) begin
        errors++;
        $display("FAIL err_onehot: got tone=%h, expected at most one bit", tone_sel);
      end
      @(posedge clk); #1;
    end
    applied++;
    if (cnt != 14) begin
      errors++;
      $display("FAIL err_len: got %0d busy cycles, expected 14", cnt);
    end
    applied++;
    if (tone_sel !== 16'h0002 || mel_id !== 2'd0) begin
      errors++;
      $display("FAIL err_resume: got tone=%h mel=%0d, expected tone=0002 mel=0", tone_sel, mel_id);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end
endmodule
